// File: rtl/cursor_control_if.sv
// rtl/cursor_control_if.sv - byte stream, cursor feedback and cursor load bundle for cursor_control
interface cursor_control_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic [5:0] cursor_x;
  logic [3:0] cursor_y;
  logic [5:0] new_cursor_x;
  logic [3:0] new_cursor_y;
  logic       write_cursor_pos;
  logic       scroll;

  // Driver side: feeds bytes and reports the current cursor position.
  modport master (
    output data, valid, cursor_x, cursor_y,
    input  ready, new_cursor_x, new_cursor_y, write_cursor_pos, scroll
  );

  // Decoder side.
  modport slave (
    input  data, valid, cursor_x, cursor_y,
    output ready, new_cursor_x, new_cursor_y, write_cursor_pos, scroll
  );
endinterface

// File: rtl/cursor_control.sv
// rtl/cursor_control.sv - terminal byte decoder driving cursor moves and scroll
module cursor_control #(
  parameter int COLS = 64,
  parameter int ROWS = 16
) (
  input logic             px_clk,
  input logic             clr,
  cursor_control_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ESC, Y_ROW, Y_COL} state_t;

  // Limits held at 8 bits so every sum/difference below has headroom before clamping.
  localparam logic [7:0] X_MAX = 8'(COLS - 1);
  localparam logic [7:0] Y_MAX = 8'(ROWS - 1);

  state_t     state, state_next;
  logic       ready_q;
  logic       accept;
  logic [3:0] row_q, row_next;
  logic [7:0] x_ext, y_ext, coord;
  logic [7:0] x_calc, y_calc;
  logic       write_c, scroll_c;

  assign accept = bus.valid && ready_q;
  assign bus.ready = ready_q;
  assign x_ext = {2'b00, bus.cursor_x};
  assign y_ext = {4'b0000, bus.cursor_y};
  // Direct-addressing coordinate; bytes below the space character map to 0.
  assign coord = (bus.data < 8'h20) ? 8'h00 : (bus.data - 8'h20);

  // State register.
  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_next;
  end

  // Decode the accepted byte into the next state and target position.
  always_comb begin
    state_next = state;
    row_next   = row_q;
    x_calc     = x_ext;
    y_calc     = y_ext;
    scroll_c   = 1'b0;
    if (accept) begin
      state_next = IDLE;
      case (state)
        IDLE: begin
          if (bus.data == 8'h08) begin
            x_calc = (x_ext == 8'd0) ? 8'd0 : x_ext - 8'd1;
          end else if (bus.data == 8'h09) begin
            x_calc = (x_ext & 8'hF8) + 8'd8;
            if (x_calc > X_MAX) x_calc = X_MAX;
          end else if (bus.data == 8'h0A) begin
            if (y_ext < Y_MAX) y_calc = y_ext + 8'd1;
            else               scroll_c = 1'b1;
          end else if (bus.data == 8'h0D) begin
            x_calc = 8'd0;
          end else if (bus.data == 8'h1B) begin
            state_next = ESC;
          end else if (bus.data >= 8'h20 && bus.data <= 8'h7E) begin
            x_calc = (x_ext < X_MAX) ? x_ext + 8'd1 : X_MAX;
          end
        end
        ESC: begin
          case (bus.data)
            8'h41: y_calc = (y_ext == 8'd0) ? 8'd0 : y_ext - 8'd1;
            8'h42: y_calc = (y_ext < Y_MAX) ? y_ext + 8'd1 : Y_MAX;
            8'h43: x_calc = (x_ext < X_MAX) ? x_ext + 8'd1 : X_MAX;
            8'h44: x_calc = (x_ext == 8'd0) ? 8'd0 : x_ext - 8'd1;
            8'h48: begin
              x_calc = 8'd0;
              y_calc = 8'd0;
            end
            8'h59: state_next = Y_ROW;
            default: ;
          endcase
        end
        Y_ROW: begin
          row_next   = (coord > Y_MAX) ? Y_MAX[3:0] : coord[3:0];
          state_next = Y_COL;
        end
        Y_COL: begin
          x_calc = (coord > X_MAX) ? X_MAX : coord;
          y_calc = {4'b0000, row_q};
        end
        default: ;
      endcase
    end
    write_c = accept && ((x_calc != x_ext) || (y_calc != y_ext));
  end

  // Handshake throttle, one-cycle strobes, held load coordinates and latched row.
  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) begin
      ready_q              <= 1'b1;
      bus.write_cursor_pos <= 1'b0;
      bus.scroll           <= 1'b0;
      bus.new_cursor_x     <= 6'd0;
      bus.new_cursor_y     <= 4'd0;
      row_q                <= 4'd0;
    end else begin
      ready_q              <= ~accept;
      bus.write_cursor_pos <= write_c;
      bus.scroll           <= scroll_c;
      row_q                <= row_next;
      if (write_c) begin
        bus.new_cursor_x <= x_calc[5:0];
        bus.new_cursor_y <= y_calc[3:0];
      end
    end
  end

endmodule
